// File: rtl/i2c_slave_tx.sv
// I2C slave transmit path: shifts upstream bytes out MSB-first on SDA during SCL low
// phases, then releases SDA and reports the master's ACK/NACK.
module i2c_slave_tx #(
    parameter int unsigned NUM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tx_enable,
    input  logic                rising_edge_found,
    input  logic                falling_edge_found,
    input  logic                start_found,
    input  logic                stop_found,
    input  logic                sda_in,
    input  logic [NUM_BITS-1:0] tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic                sda_out,
    output logic                ack_received,
    output logic                nack_received,
    output logic                underrun,
    output logic                busy
);

    localparam int unsigned CW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(NUM_BITS - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LOAD     = 3'd1;
    localparam logic [2:0] SHIFT    = 3'd2;
    localparam logic [2:0] ACK_WAIT = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;

    logic [2:0]          state, state_d;
    logic [NUM_BITS-1:0] shift_reg, shift_d;
    logic [CW-1:0]       bit_cnt, cnt_d;
    logic                sda_d, ack_d, nack_d;
    logic                abort, scl_fall, scl_rise;

    // Coincident rise and fall pulses are illegal and both get dropped.
    assign scl_fall = falling_edge_found & ~rising_edge_found;
    assign scl_rise = rising_edge_found & ~falling_edge_found;
    assign abort    = ~tx_enable | start_found | stop_found;
    assign busy     = (state != IDLE);

    always_comb begin
        state_d  = state;
        shift_d  = shift_reg;
        cnt_d    = bit_cnt;
        sda_d    = sda_out;
        ack_d    = 1'b0;
        nack_d   = 1'b0;
        tx_ready = 1'b0;
        underrun = 1'b0;

        if (state != IDLE && abort) begin
            state_d = IDLE;
            sda_d   = 1'b1;
            cnt_d   = '0;
        end else begin
            case (state)
                IDLE: begin
                    sda_d = 1'b1;
                    cnt_d = '0;
                    if (!abort) begin
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    sda_d = 1'b1;
                    if (scl_fall) begin
                        cnt_d   = '0;
                        state_d = SHIFT;
                        if (tx_valid) begin
                            shift_d  = tx_data;
                            sda_d    = tx_data[NUM_BITS-1];
                            tx_ready = 1'b1;
                        end else begin
                            // No clock stretching: an empty slot goes out as all ones.
                            shift_d  = '1;
                            sda_d    = 1'b1;
                            underrun = 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (scl_fall) begin
                        if (bit_cnt == LAST_BIT) begin
                            sda_d   = 1'b1;
                            state_d = ACK_WAIT;
                        end else begin
                            shift_d = (shift_reg << 1) | {{(NUM_BITS-1){1'b0}}, 1'b1};
                            sda_d   = shift_d[NUM_BITS-1];
                            cnt_d   = bit_cnt + 1'b1;
                        end
                    end
                end
                ACK_WAIT: begin
                    sda_d = 1'b1;
                    if (scl_rise) begin
                        if (sda_in) begin
                            nack_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            ack_d   = 1'b1;
                            state_d = LOAD;
                        end
                    end
                end
                DONE: begin
                    sda_d = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                    sda_d   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            shift_reg     <= '1;
            bit_cnt       <= '0;
            sda_out       <= 1'b1;
            ack_received  <= 1'b0;
            nack_received <= 1'b0;
        end else begin
            state         <= state_d;
            shift_reg     <= shift_d;
            bit_cnt       <= cnt_d;
            sda_out       <= sda_d;
            ack_received  <= ack_d;
            nack_received <= nack_d;
        end
    end

endmodule

// File: tb/tb_i2c_slave_tx.sv
// Directed bench for i2c_slave_tx: byte streams, ACK/NACK, underrun, abort and reset.
module tb_i2c_slave_tx;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_SHIFT    = 3'd2;
    localparam logic [2:0] S_ACK_WAIT = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    logic       clk = 1'b0;
    logic       rst, tx_enable, rising_edge_found, falling_edge_found;
    logic       start_found, stop_found, sda_in, tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready, sda_out, ack_received, nack_received, underrun, busy;

    int tests = 0;
    int fails = 0;
    int n_rdy = 0, n_und = 0, n_ack = 0, n_nack = 0;
    int s_rdy, s_und, s_ack, s_nack;
    logic [7:0] got_byte;

    i2c_slave_tx #(.NUM_BITS(8)) dut (
        .clk                (clk),
        .rst                (rst),
        .tx_enable          (tx_enable),
        .rising_edge_found  (rising_edge_found),
        .falling_edge_found (falling_edge_found),
        .start_found        (start_found),
        .stop_found         (stop_found),
        .sda_in             (sda_in),
        .tx_data            (tx_data),
        .tx_valid           (tx_valid),
        .tx_ready           (tx_ready),
        .sda_out            (sda_out),
        .ack_received       (ack_received),
        .nack_received      (nack_received),
        .underrun           (underrun),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_ready)      n_rdy++;
        if (underrun)      n_und++;
        if (ack_received)  n_ack++;
        if (nack_received) n_nack++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        s_rdy = n_rdy; s_und = n_und; s_ack = n_ack; s_nack = n_nack;
    endtask

    task automatic scl_fall();
        falling_edge_found = 1'b1;
        tick();
        falling_edge_found = 1'b0;
        tick();
    endtask

    task automatic scl_rise(input logic sda);
        sda_in = sda;
        rising_edge_found = 1'b1;
        tick();
        rising_edge_found = 1'b0;
        tick();
        tick();
        sda_in = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tx_enable = 1'b0; rising_edge_found = 1'b0; falling_edge_found = 1'b0;
        start_found = 1'b0; stop_found = 1'b0; sda_in = 1'b1;
        tx_valid = 1'b0; tx_data = 8'h00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Eight data falling edges, assembling what appeared on sda_out after each.
    task automatic shift_byte(output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            scl_fall();
            b[i] = sda_out;
        end
    endtask

    initial begin
        do_reset();
        check("reset_sda", sda_out, 1);
        check("reset_busy", busy, 0);
        check("reset_state", dut.state, S_IDLE);
        check("reset_cnt", dut.bit_cnt, 0);
        check("reset_shift", dut.shift_reg, 8'hFF);

        // Single byte 0xA5 with ACK.
        snap();
        tx_enable = 1'b1; tx_valid = 1'b1; tx_data = 8'hA5;
        tick();
        check("a5_load_state", dut.state, S_LOAD);
        check("a5_busy", busy, 1);
        scl_fall();
        check("a5_bit7", sda_out, 1);
        scl_fall();
        check("a5_bit6", sda_out, 0);
        for (int i = 5; i >= 0; i--) begin
            scl_fall();
            got_byte[i] = sda_out;
        end
        check("a5_bits5_0", got_byte[5:0], 6'b100101);
        scl_fall();
        check("a5_release", sda_out, 1);
        check("a5_ackwait", dut.state, S_ACK_WAIT);
        scl_rise(1'b0);
        check("a5_ready_cnt", n_rdy - s_rdy, 1);
        check("a5_ack_cnt", n_ack - s_ack, 1);
        check("a5_state_load", dut.state, S_LOAD);

        // 0x3C with ACK, then 0x81 with NACK.
        do_reset();
        snap();
        tx_enable = 1'b1; tx_valid = 1'b1; tx_data = 8'h3C;
        tick();
        shift_byte(got_byte);
        check("b3c_stream", got_byte, 8'h3C);
        scl_fall();
        scl_rise(1'b0);
        check("b3c_ack", n_ack - s_ack, 1);
        tx_data = 8'h81;
        shift_byte(got_byte);
        check("b81_stream", got_byte, 8'h81);
        scl_fall();
        scl_rise(1'b1);
        check("b81_nack", n_nack - s_nack, 1);
        check("b81_ack_total", n_ack - s_ack, 1);
        check("b81_ready_cnt", n_rdy - s_rdy, 2);
        check("b81_done", dut.state, S_DONE);
        scl_fall();
        check("done_sda_fall", sda_out, 1);
        scl_rise(1'b0);
        scl_fall();
        check("done_sda_fall2", sda_out, 1);
        check("done_stays", dut.state, S_DONE);
        check("done_no_ack", n_ack - s_ack, 1);

        // Underrun: nothing valid at the load slot.
        do_reset();
        snap();
        tx_enable = 1'b1; tx_valid = 1'b0;
        tick();
        shift_byte(got_byte);
        check("und_stream", got_byte, 8'hFF);
        check("und_pulse", n_und - s_und, 1);
        check("und_no_ready", n_rdy - s_rdy, 0);
        scl_fall();
        scl_rise(1'b0);
        check("und_ack", n_ack - s_ack, 1);

        // STOP after three bits of 0x00.
        do_reset();
        snap();
        tx_enable = 1'b1; tx_valid = 1'b1; tx_data = 8'h00;
        tick();
        scl_fall(); scl_fall(); scl_fall();
        check("stop_pre_sda", sda_out, 0);
        stop_found = 1'b1; tx_enable = 1'b0;
        tick();
        stop_found = 1'b0;
        check("stop_sda", sda_out, 1);
        check("stop_busy", busy, 0);
        check("stop_state", dut.state, S_IDLE);
        tick();
        tx_enable = 1'b1;
        tick();
        check("reenter_state", dut.state, S_LOAD);
        check("reenter_cnt", dut.bit_cnt, 0);
        scl_fall();
        check("reenter_bit7", sda_out, 0);
        check("reenter_shift", dut.state, S_SHIFT);
        check("reenter_cnt_after", dut.bit_cnt, 0);

        // Reset mid-byte while SDA is held low.
        do_reset();
        tx_enable = 1'b1; tx_valid = 1'b1; tx_data = 8'h00;
        tick();
        scl_fall(); scl_fall();
        check("rst_pre_sda", sda_out, 0);
        snap();
        rst = 1'b1; tx_enable = 1'b0;
        tick();
        rst = 1'b0;
        check("rst_sda", sda_out, 1);
        check("rst_busy", busy, 0);
        scl_fall();
        scl_rise(1'b0);
        check("rst_idle_sda", sda_out, 1);
        check("rst_idle_state", dut.state, S_IDLE);
        check("rst_no_pulses", (n_rdy - s_rdy) + (n_und - s_und) + (n_ack - s_ack)
                               + (n_nack - s_nack), 0);
        tx_enable = 1'b1;
        tick();
        check("rst_reenter", dut.state, S_LOAD);

        // tx_enable dropped while waiting for ACK.
        do_reset();
        snap();
        tx_enable = 1'b1; tx_valid = 1'b1; tx_data = 8'h5A;
        tick();
        shift_byte(got_byte);
        check("abort_stream", got_byte, 8'h5A);
        scl_fall();
        check("abort_ackwait", dut.state, S_ACK_WAIT);
        tx_enable = 1'b0;
        tick();
        scl_rise(1'b0);
        check("abort_no_ack", n_ack - s_ack, 0);
        check("abort_state", dut.state, S_IDLE);
        check("abort_sda", sda_out, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
